glay_kernel_cu_descriptor_dispatch: RTL and testbench

- Sits directly downstream of the kernel control stage, between it and the graph clusters.
- Detects the start of a descriptor-valid window, latches the descriptor payload and broadcasts it to every cluster with a per-cluster valid/ready handshake.
- Tracks per-cluster setup completion and per-cluster run completion, and returns the cu_setup and cu_done vectors that the control stage consumes.
- Maintains a busy-cycle counter and a run counter for host readback.

---
 rtl/glay_kernel_cu_descriptor_dispatch.sv | 154 +++++++++++++++
 tb/tb_glay_kernel_cu_descriptor_dispatch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glay_kernel_cu_descriptor_dispatch.sv
// Descriptor dispatcher: latches a descriptor on the rising edge of the valid window,
// offers it to every graph cluster, and gathers per-cluster setup/done status.
module glay_kernel_cu_descriptor_dispatch #(
   parameter int NUM_GRAPH_CLUSTERS = 4,
   parameter int PAYLOAD_W          = 512,
   parameter int CYCLE_CNT_W        = 32
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst_n,
   input  logic                          descriptor_in_valid,
   input  logic [PAYLOAD_W-1:0]          descriptor_in_payload,
   input  logic [NUM_GRAPH_CLUSTERS-1:0] cluster_setup_done_in,
   output logic [NUM_GRAPH_CLUSTERS-1:0] cluster_desc_valid_out,
   input  logic [NUM_GRAPH_CLUSTERS-1:0] cluster_desc_ready_in,
   output logic [PAYLOAD_W-1:0]          cluster_desc_payload_out,
   input  logic [NUM_GRAPH_CLUSTERS-1:0] cluster_done_in,
   output logic [NUM_GRAPH_CLUSTERS-1:0] glay_cu_setup_out,
   output logic [NUM_GRAPH_CLUSTERS-1:0] glay_cu_done_out,
   output logic [CYCLE_CNT_W-1:0]        busy_cycles_out,
   output logic [15:0]                   run_count_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_DISPATCH,
      S_RUN,
      S_DONE
   } state_t;

   state_t                        state_reg, state_next;
   logic                          valid_q_reg;
   logic [PAYLOAD_W-1:0]          payload_reg;
   logic [NUM_GRAPH_CLUSTERS-1:0] sent_mask_reg, sent_mask_next;
   logic [NUM_GRAPH_CLUSTERS-1:0] done_mask_reg, done_mask_next;
   logic [NUM_GRAPH_CLUSTERS-1:0] valid_out_reg, valid_out_next;
   logic [NUM_GRAPH_CLUSTERS-1:0] setup_reg;
   logic [CYCLE_CNT_W-1:0]        busy_reg, busy_next;
   logic [15:0]                   run_cnt_reg, run_cnt_next;
   logic                          latch_en;
   logic                          rise;
   logic [NUM_GRAPH_CLUSTERS-1:0] handshake;
   logic [NUM_GRAPH_CLUSTERS-1:0] done_accept;

   assign rise = descriptor_in_valid & ~valid_q_reg;

   // A done pulse only counts once the cluster's handshake is already registered,
   // so a same-cycle handshake and done pulse drops the done.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_GRAPH_CLUSTERS; gi++) begin : g_cluster
         assign handshake[gi]   = valid_out_reg[gi] & cluster_desc_ready_in[gi];
         assign done_accept[gi] = cluster_done_in[gi] & sent_mask_reg[gi];
      end
   endgenerate

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_reg     <= S_IDLE;
         valid_q_reg   <= 1'b0;
         payload_reg   <= '0;
         sent_mask_reg <= '0;
         done_mask_reg <= '0;
         valid_out_reg <= '0;
         setup_reg     <= '1;
         busy_reg      <= '0;
         run_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         valid_q_reg   <= descriptor_in_valid;
         if (latch_en) begin
            payload_reg <= descriptor_in_payload;
         end
         sent_mask_reg <= sent_mask_next;
         done_mask_reg <= done_mask_next;
         valid_out_reg <= valid_out_next;
         setup_reg     <= setup_reg & ~cluster_setup_done_in;
         busy_reg      <= busy_next;
         run_cnt_reg   <= run_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      sent_mask_next = sent_mask_reg;
      done_mask_next = done_mask_reg;
      busy_next      = busy_reg;
      run_cnt_next   = run_cnt_reg;
      latch_en       = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (rise) begin
               state_next = S_LATCH;
            end
         end
         S_LATCH: begin
            sent_mask_next = '0;
            done_mask_next = '0;
            if (!descriptor_in_valid) begin
               state_next = S_IDLE;
            end else begin
               latch_en   = 1'b1;
               busy_next  = '0;
               state_next = S_DISPATCH;
            end
         end
         S_DISPATCH, S_RUN: begin
            if (!descriptor_in_valid) begin
               state_next     = S_IDLE;
               sent_mask_next = '0;
               done_mask_next = '0;
            end else begin
               if (busy_reg != {CYCLE_CNT_W{1'b1}}) begin
                  busy_next = busy_reg + CYCLE_CNT_W'(1);
               end
               sent_mask_next = sent_mask_reg | handshake;
               done_mask_next = done_mask_reg | done_accept;
               if (state_reg == S_DISPATCH) begin
                  if (&sent_mask_next) begin
                     state_next = S_RUN;
                  end
               end else if (&done_mask_next) begin
                  state_next   = S_DONE;
                  run_cnt_next = run_cnt_reg + 16'd1;
               end
            end
         end
         S_DONE: begin
            if (!descriptor_in_valid) begin
               state_next     = S_IDLE;
               done_mask_next = '0;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Offers appear only from the second DISPATCH cycle and drop after their handshake.
      valid_out_next = '0;
      if (state_reg == S_DISPATCH && state_next == S_DISPATCH) begin
         valid_out_next = ~sent_mask_next;
      end
   end

   assign cluster_desc_valid_out   = valid_out_reg;
   assign cluster_desc_payload_out = payload_reg;
   assign glay_cu_setup_out        = setup_reg;
   assign glay_cu_done_out         = done_mask_reg;
   assign busy_cycles_out          = busy_reg;
   assign run_count_out            = run_cnt_reg;

endmodule

// File: tb/tb_glay_kernel_cu_descriptor_dispatch.sv
// Bench for the descriptor dispatcher: directed scenarios plus random traffic,
// compared against an event-level reference model every cycle.
module tb_glay_kernel_cu_descriptor_dispatch;

   logic         ap_clk;
   logic         ap_rst_n;
   logic         descriptor_in_valid;
   logic [511:0] descriptor_in_payload;
   logic [3:0]   cluster_setup_done_in;
   logic [3:0]   cluster_desc_valid_out;
   logic [3:0]   cluster_desc_ready_in;
   logic [511:0] cluster_desc_payload_out;
   logic [3:0]   cluster_done_in;
   logic [3:0]   glay_cu_setup_out;
   logic [3:0]   glay_cu_done_out;
   logic [31:0]  busy_cycles_out;
   logic [15:0]  run_count_out;

   int errors = 0;
   int checks = 0;

   glay_kernel_cu_descriptor_dispatch #(
      .NUM_GRAPH_CLUSTERS(4),
      .PAYLOAD_W(512),
      .CYCLE_CNT_W(32)
   ) dut (
      .ap_clk(ap_clk),
      .ap_rst_n(ap_rst_n),
      .descriptor_in_valid(descriptor_in_valid),
      .descriptor_in_payload(descriptor_in_payload),
      .cluster_setup_done_in(cluster_setup_done_in),
      .cluster_desc_valid_out(cluster_desc_valid_out),
      .cluster_desc_ready_in(cluster_desc_ready_in),
      .cluster_desc_payload_out(cluster_desc_payload_out),
      .cluster_done_in(cluster_done_in),
      .glay_cu_setup_out(glay_cu_setup_out),
      .glay_cu_done_out(glay_cu_done_out),
      .busy_cycles_out(busy_cycles_out),
      .run_count_out(run_count_out)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   // Reference model: tracks the phase of the current run and what each cluster has seen.
   typedef enum int {P_IDLE, P_LATCH, P_DISPATCH, P_RUN, P_DONE} phase_t;
   phase_t       m_phase;
   logic [3:0]   m_setup, m_offer, m_sent, m_done;
   logic [511:0] m_payload;
   logic [31:0]  m_busy;
   logic [15:0]  m_runs;
   logic         m_prev_valid;

   always @(posedge ap_clk or negedge ap_rst_n) begin
      logic [3:0] accepted;
      logic [3:0] finished;
      if (!ap_rst_n) begin
         m_phase = P_IDLE; m_setup = 4'hF; m_offer = 4'h0; m_sent = 4'h0; m_done = 4'h0;
         m_payload = '0; m_busy = 32'd0; m_runs = 16'd0; m_prev_valid = 1'b0;
      end else begin
         accepted = m_offer & cluster_desc_ready_in;
         finished = cluster_done_in & m_sent;
         m_setup  = m_setup & ~cluster_setup_done_in;
         m_offer  = 4'h0;
         if (!descriptor_in_valid && (m_phase inside {P_LATCH, P_DISPATCH, P_RUN})) begin
            m_phase = P_IDLE; m_sent = 4'h0; m_done = 4'h0;
         end else begin
            case (m_phase)
               P_IDLE: if (descriptor_in_valid && !m_prev_valid) m_phase = P_LATCH;
               P_LATCH: begin
                  m_payload = descriptor_in_payload;
                  m_sent = 4'h0; m_done = 4'h0; m_busy = 32'd0;
                  m_phase = P_DISPATCH;
               end
               P_DISPATCH: begin
                  if (m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 32'd1;
                  m_done = m_done | finished;
                  m_sent = m_sent | accepted;
                  if (m_sent == 4'hF) m_phase = P_RUN;
                  else m_offer = ~m_sent;
               end
               P_RUN: begin
                  if (m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 32'd1;
                  m_done = m_done | finished;
                  if (m_done == 4'hF) begin
                     m_phase = P_DONE;
                     m_runs  = m_runs + 16'd1;
                  end
               end
               P_DONE: if (!descriptor_in_valid) begin
                  m_phase = P_IDLE; m_done = 4'h0;
               end
               default: m_phase = P_IDLE;
            endcase
         end
         m_prev_valid = descriptor_in_valid;
      end
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("model_setup", 512'(glay_cu_setup_out), 512'(m_setup));
      check("model_valid_out", 512'(cluster_desc_valid_out), 512'(m_offer));
      check("model_payload", cluster_desc_payload_out, m_payload);
      check("model_done_out", 512'(glay_cu_done_out), 512'(m_done));
      check("model_busy", 512'(busy_cycles_out), 512'(m_busy));
      check("model_runs", 512'(run_count_out), 512'(m_runs));
   endtask

   task automatic tick(input logic [3:0] rdy, input logic [3:0] dn, input logic [3:0] su);
      cluster_desc_ready_in = rdy;
      cluster_done_in       = dn;
      cluster_setup_done_in = su;
      @(negedge ap_clk);
      check_all();
   endtask

   function automatic logic [511:0] rand_payload();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_setup"}, 512'(glay_cu_setup_out), 512'(4'hF));
      check({tag, "_valid_out"}, 512'(cluster_desc_valid_out), 512'(4'h0));
      check({tag, "_payload"}, cluster_desc_payload_out, 512'd0);
      check({tag, "_done_out"}, 512'(glay_cu_done_out), 512'(4'h0));
      check({tag, "_busy"}, 512'(busy_cycles_out), 512'd0);
      check({tag, "_runs"}, 512'(run_count_out), 512'd0);
   endtask

   initial begin
      logic [511:0] a5;
      logic [15:0]  last_runs;
      a5 = {64{8'hA5}};
      ap_rst_n = 1'b0;
      descriptor_in_valid = 1'b0;
      descriptor_in_payload = '0;
      cluster_setup_done_in = 4'h0;
      cluster_desc_ready_in = 4'h0;
      cluster_done_in = 4'h0;

      repeat (2) @(negedge ap_clk);
      check_reset_values("reset");
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      check_all();

      tick(4'h0, 4'h0, 4'b0101);
      check("setup_step1", 512'(glay_cu_setup_out), 512'(4'b1010));
      tick(4'h0, 4'h0, 4'b1010);
      check("setup_step2", 512'(glay_cu_setup_out), 512'(4'b0000));
      $display("step setup: setup_out=%b", glay_cu_setup_out);

      // Run A: all clusters ready, done pulses in order 3,0,1,2
      descriptor_in_payload = a5;
      descriptor_in_valid = 1'b1;
      tick(4'hF, 4'h0, 4'h0);
      tick(4'hF, 4'h0, 4'h0);
      check("runA_payload", cluster_desc_payload_out, a5);
      check("runA_valid_pre", 512'(cluster_desc_valid_out), 512'(4'h0));
      tick(4'hF, 4'h0, 4'h0);
      check("runA_valid_on", 512'(cluster_desc_valid_out), 512'(4'hF));
      tick(4'hF, 4'h0, 4'h0);
      check("runA_valid_off", 512'(cluster_desc_valid_out), 512'(4'h0));
      tick(4'h0, 4'b1000, 4'h0);
      check("runA_done1", 512'(glay_cu_done_out), 512'(4'b1000));
      tick(4'h0, 4'b0001, 4'h0);
      check("runA_done2", 512'(glay_cu_done_out), 512'(4'b1001));
      tick(4'h0, 4'b0010, 4'h0);
      check("runA_done3", 512'(glay_cu_done_out), 512'(4'b1011));
      tick(4'h0, 4'b0100, 4'h0);
      check("runA_done4", 512'(glay_cu_done_out), 512'(4'b1111));
      check("runA_runs", 512'(run_count_out), 512'd1);
      check("runA_busy", 512'(busy_cycles_out), 512'd6);
      tick(4'h0, 4'h0, 4'h0);
      check("runA_done_hold", 512'(glay_cu_done_out), 512'(4'hF));
      descriptor_in_valid = 1'b0;
      tick(4'h0, 4'h0, 4'h0);
      check("runA_done_clear", 512'(glay_cu_done_out), 512'(4'h0));
      check("runA_busy_hold", 512'(busy_cycles_out), 512'd6);
      $display("step runA: runs=%0d busy=%0d", run_count_out, busy_cycles_out);

      // Run B: early done on cluster 1 must be dropped
      descriptor_in_payload = rand_payload();
      descriptor_in_valid = 1'b1;
      repeat (3) tick(4'b1101, 4'h0, 4'h0);
      check("runB_valid_on", 512'(cluster_desc_valid_out), 512'(4'hF));
      tick(4'b1101, 4'h0, 4'h0);
      check("runB_valid_pending", 512'(cluster_desc_valid_out), 512'(4'b0010));
      tick(4'b1101, 4'b0010, 4'h0);
      check("runB_early_done", 512'(glay_cu_done_out), 512'(4'h0));
      tick(4'hF, 4'h0, 4'h0);
      tick(4'h0, 4'b1101, 4'h0);
      check("runB_partial", 512'(glay_cu_done_out), 512'(4'b1101));
      tick(4'h0, 4'h0, 4'h0);
      check("runB_not_done", 512'(run_count_out), 512'd1);
      tick(4'h0, 4'b0010, 4'h0);
      check("runB_done", 512'(glay_cu_done_out), 512'(4'hF));
      check("runB_runs", 512'(run_count_out), 512'd2);
      descriptor_in_valid = 1'b0;
      tick(4'h0, 4'h0, 4'h0);
      $display("step runB: runs=%0d busy=%0d", run_count_out, busy_cycles_out);

      // Run C: cluster 2 ready late
      descriptor_in_payload = rand_payload();
      descriptor_in_valid = 1'b1;
      repeat (8) tick(4'b1011, 4'h0, 4'h0);
      check("runC_pending", 512'(cluster_desc_valid_out), 512'(4'b0100));
      tick(4'hF, 4'h0, 4'h0);
      tick(4'h0, 4'b1000, 4'h0);
      tick(4'h0, 4'b0001, 4'h0);
      tick(4'h0, 4'b0010, 4'h0);
      tick(4'h0, 4'b0100, 4'h0);
      check("runC_runs", 512'(run_count_out), 512'd3);
      check("runC_busy", 512'(busy_cycles_out), 512'd11);
      descriptor_in_valid = 1'b0;
      tick(4'h0, 4'h0, 4'h0);
      $display("step runC: runs=%0d busy=%0d", run_count_out, busy_cycles_out);

      // Run D: abort in DISPATCH with clusters 2 and 3 pending
      descriptor_in_payload = rand_payload();
      descriptor_in_valid = 1'b1;
      repeat (4) tick(4'b0011, 4'h0, 4'h0);
      check("runD_pending", 512'(cluster_desc_valid_out), 512'(4'b1100));
      descriptor_in_valid = 1'b0;
      tick(4'b0011, 4'h0, 4'h0);
      check("runD_abort_valid", 512'(cluster_desc_valid_out), 512'(4'h0));
      check("runD_abort_busy", 512'(busy_cycles_out), 512'd2);
      check("runD_abort_runs", 512'(run_count_out), 512'd3);
      tick(4'hF, 4'h0, 4'h0);
      $display("step runD: aborted, busy=%0d", busy_cycles_out);

      // Random traffic
      last_runs = m_runs;
      for (int c = 0; c < 600; c++) begin
         if (descriptor_in_valid) begin
            if ($urandom_range(0, 29) == 0) descriptor_in_valid = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            descriptor_in_payload = rand_payload();
            descriptor_in_valid = 1'b1;
         end
         tick(4'($urandom), 4'($urandom) & 4'($urandom), 4'h0);
         if (m_runs != last_runs) begin
            $display("random run complete: runs=%0d busy=%0d", run_count_out, busy_cycles_out);
            last_runs = m_runs;
         end
      end

      // Reset asserted during RUN
      descriptor_in_valid = 1'b0;
      tick(4'h0, 4'h0, 4'h0);
      tick(4'h0, 4'h0, 4'h0);
      descriptor_in_payload = rand_payload();
      descriptor_in_valid = 1'b1;
      repeat (4) tick(4'hF, 4'h0, 4'h0);
      tick(4'h0, 4'b0001, 4'h0);
      check("rstrun_done_before", 512'(glay_cu_done_out), 512'(4'b0001));
      #2 ap_rst_n = 1'b0;
      #1 check_reset_values("rst_in_run");
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      descriptor_in_valid = 1'b0;
      tick(4'h0, 4'h0, 4'h0);
      $display("step reset_in_run: setup_out=%b runs=%0d", glay_cu_setup_out, run_count_out);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
